t_toggle_monitor: RTL and testbench
===================================

T_TOGGLE_MONITOR -- requirements
Module: t_toggle_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of toggle count.
REQ-002 SHALL have parameter WIN_W, default 8, width of measurement window length.
REQ-003 SHALL have parameter STUCK_LIM, default 16, idle-cycle limit for stuck detection.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port q_in  input  1  q output of upstream T stage, asynchronous to clk.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-008 SHALL have port win_len  input  WIN_W  window length in clk cycles, sampled on accepted start.
REQ-009 SHALL have port ack  input  1  consumer acknowledges result.
REQ-010 SHALL have port busy  output  1  high while measuring.
REQ-011 SHALL have port done  output  1  result valid, held until ack.
REQ-012 SHALL have port count_o  output  CNT_W  number of q_in transitions in the window.
REQ-013 SHALL have port ovf_o  output  1  count saturated during the window.
REQ-014 SHALL have port edge_o  output  1  one-cycle pulse per detected q_in transition.
REQ-015 SHALL have port stuck_o  output  1  no transition for STUCK_LIM cycles while measuring.

Function
REQ-016 SHALL synchronise q_in through two flops (s1, s2) and a third delay flop d; edge = s2 XOR d.
REQ-017 SHALL assert edge_o for exactly one cycle per q_in level change, 3 clk edges after the change is first sampled; both rising and falling counted.
REQ-018 SHALL implement FSM states IDLE, MEASURE, DONE.
REQ-019 IDLE: start=1 with win_len!=0 -> MEASURE next cycle, window counter loaded with win_len, count_o and ovf_o cleared.
REQ-020 IDLE: start=1 with win_len=0 -> DONE next cycle with count_o=0, ovf_o=0.
REQ-021 MEASURE: SHALL count edge pulses on exactly win_len consecutive cycles, then enter DONE.
REQ-022 count_o SHALL saturate at 2^CNT_W-1; further edges set ovf_o, never wrap.
REQ-023 start SHALL be ignored in MEASURE and DONE.
REQ-024 DONE: done=1, count_o/ovf_o stable; ack=1 -> IDLE next cycle, done low.
REQ-025 ack and start together in DONE: ack wins, start ignored that cycle.
REQ-026 busy SHALL equal (state==MEASURE); done SHALL equal (state==DONE).
REQ-027 count_o and ovf_o SHALL hold their last result in IDLE until next accepted start.
REQ-028 edge_o SHALL operate in all states.

Reset
REQ-029 rst=0 at a rising clk edge SHALL force IDLE, s1/s2/d=0, count_o=0, ovf_o=0, stuck_o=0, busy=0, done=0, edge_o=0.
REQ-030 reset mid-measurement SHALL abort the window with no done pulse.

Configuration
REQ-031 Macro TMON_STUCK_DETECT_EN defined: idle counter runs in MEASURE, clears on edge; reaching STUCK_LIM sets stuck_o, sticky until next accepted start or reset.
REQ-032 Macro TMON_STUCK_DETECT_EN undefined: no idle counter; stuck_o port present, tied 0.

Structure
REQ-033 Package tmon_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-034 Synchroniser and edge detector SHALL be sub-module tmon_sync_edge (ports clk, rst, d_in, level_o, edge_o).

Verification
REQ-035 q_in toggled every 4 cycles, start with win_len=20 -> done after 20 cycles, count_o=5, ovf_o=0.
REQ-036 CNT_W=4, q_in toggled every cycle, win_len=40 -> count_o=15, ovf_o=1.
REQ-037 start with win_len=0 -> done next cycle, count_o=0; ack with start same cycle -> IDLE, no new measurement.
REQ-038 rst=0 at cycle 5 of a win_len=30 window -> IDLE, busy=0, count_o=0, done never asserted.
REQ-039 TMON_STUCK_DETECT_EN defined, q_in constant, win_len=40 -> stuck_o=1 on MEASURE cycle 16, held until next start; undefined -> stuck_o=0.
REQ-040 Single q_in 0->1 pulse of 1 clk width -> exactly two edge_o pulses, in consecutive cycles.

Source files
------------

// File: rtl/tmon_pkg.sv
// tmon_pkg: shared types and default sizing for the toggle monitor.
package tmon_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_DONE
  } tmon_state_e;

  localparam int TMON_CNT_W     = 8;
  localparam int TMON_WIN_W     = 8;
  localparam int TMON_STUCK_LIM = 16;

endpackage

// File: rtl/tmon_sync_edge.sv
// tmon_sync_edge: two-flop synchroniser plus delay flop.
// edge_o pulses one cycle for each level change of d_in.
module tmon_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level_o,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= d_in;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign edge_o  = s2_q ^ d_q;

endmodule

// File: rtl/t_toggle_monitor.sv
// t_toggle_monitor: counts q_in transitions over a programmable window.
// Define TMON_STUCK_DETECT_EN to enable the stuck (no-toggle) detector.
module t_toggle_monitor
  import tmon_pkg::*;
#(
  parameter int CNT_W     = TMON_CNT_W,
  parameter int WIN_W     = TMON_WIN_W,
  parameter int STUCK_LIM = TMON_STUCK_LIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o,
  output logic             edge_o,
  output logic             stuck_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  tmon_state_e      state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             edge_w;
  logic             lvl_unused;
  logic             start_acc;

  tmon_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (q_in),
    .level_o(lvl_unused),
    .edge_o (edge_w)
  );

  assign start_acc = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (win_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MEASURE;
            win_d   = win_len;
          end
        end
      end
      S_MEASURE: begin
        // Saturate rather than wrap; extra edges only flag overflow.
        if (edge_w) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
        win_d = win_q - 1'b1;
        if (win_q == WIN_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = (state_q == S_MEASURE);
  assign done    = (state_q == S_DONE);
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
  assign edge_o  = edge_w;

`ifdef TMON_STUCK_DETECT_EN
  localparam int IDLE_W = $clog2(STUCK_LIM + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              stuck_q, stuck_d;

  always_comb begin
    idle_d  = idle_q;
    stuck_d = stuck_q;
    if (start_acc) begin
      idle_d  = '0;
      stuck_d = 1'b0;
    end else if (state_q == S_MEASURE) begin
      if (edge_w) begin
        idle_d = '0;
      end else begin
        if (idle_q != IDLE_W'(STUCK_LIM)) idle_d = idle_q + 1'b1;
        if (idle_q == IDLE_W'(STUCK_LIM - 1)) stuck_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_q  <= '0;
      stuck_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck_o = stuck_q;
`else
  localparam int lim_unused = STUCK_LIM;
  logic          acc_unused;

  assign acc_unused = start_acc;
  assign stuck_o    = 1'b0;
`endif

endmodule

// File: tb/tb_t_toggle_monitor.sv
// tb_t_toggle_monitor: directed vectors for the toggle monitor.
// Runs a default-width and a CNT_W=4 instance side by side.
module tb_t_toggle_monitor;

`ifdef TMON_STUCK_DETECT_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       q_in;
  logic       start = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic       ack = 1'b0;

  logic       busy, done, ovf8, edge8, stuck8;
  logic [7:0] cnt8;
  logic       busy4, done4, ovf4, edge4, stuck4;
  logic [3:0] cnt4;

  int per = -1;
  int pulse_req = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  t_toggle_monitor #(.CNT_W(8), .WIN_W(8), .STUCK_LIM(16)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .start(start),
    .win_len(win_len), .ack(ack), .busy(busy), .done(done),
    .count_o(cnt8), .ovf_o(ovf8), .edge_o(edge8), .stuck_o(stuck8)
  );

  t_toggle_monitor #(.CNT_W(4), .WIN_W(8), .STUCK_LIM(16)) dut4 (
    .clk(clk), .rst(rst), .q_in(q_in), .start(start),
    .win_len(win_len), .ack(ack), .busy(busy4), .done(done4),
    .count_o(cnt4), .ovf_o(ovf4), .edge_o(edge4), .stuck_o(stuck4)
  );

  // q_in driver: per>0 toggles every per cycles, 0 holds, <0 forces low
  initial begin
    int ph;
    int seen;
    ph = 0;
    seen = 0;
    q_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (seen != pulse_req) begin
        q_in = 1'b1;
        seen = pulse_req;
      end else if (per < 0) begin
        q_in = 1'b0;
      end else if (per > 0) begin
        ph++;
        if (ph >= per) begin
          ph = 0;
          q_in = ~q_in;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic go(input int w);
    @(negedge clk);
    start = 1'b1;
    win_len = w[7:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_n);
    int n;
    n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  typedef struct {
    int per;
    int win;
    int c8;
    bit o8;
    int c4;
    bit o4;
  } vec_t;

  vec_t vt[9];

  initial begin
    int first, last, npulse, n4, ndone;

    vt[0] = '{4, 20, 5, 1'b0, 5, 1'b0};
    vt[1] = '{1, 40, 40, 1'b0, 15, 1'b1};
    vt[2] = '{0, 10, 0, 1'b0, 0, 1'b0};
    vt[3] = '{2, 10, 5, 1'b0, 5, 1'b0};
    vt[4] = '{1, 1, 1, 1'b0, 1, 1'b0};
    vt[5] = '{1, 15, 15, 1'b0, 15, 1'b0};
    vt[6] = '{1, 16, 16, 1'b0, 15, 1'b1};
    vt[7] = '{1, 255, 255, 1'b0, 15, 1'b1};
    vt[8] = '{0, 0, 0, 1'b0, 0, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_edge", edge8, 0);
    chk("rst_stuck", stuck8, 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      per = vt[i].per;
      repeat (8) @(negedge clk);
      go(vt[i].win);
      chk($sformatf("v%0d_busy", i), busy, vt[i].win != 0);
      wait_done($sformatf("v%0d_lat", i), vt[i].win);
      chk($sformatf("v%0d_cnt8", i), cnt8, vt[i].c8);
      chk($sformatf("v%0d_ovf8", i), ovf8, vt[i].o8);
      chk($sformatf("v%0d_cnt4", i), cnt4, vt[i].c4);
      chk($sformatf("v%0d_ovf4", i), ovf4, vt[i].o4);
      chk($sformatf("v%0d_done4", i), done4, 1);
      chk($sformatf("v%0d_stuck", i), stuck8, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_hold_done", i), done, 1);
      chk($sformatf("v%0d_hold_cnt", i), cnt8, vt[i].c8);
      do_ack();
      chk($sformatf("v%0d_ack_done", i), done, 0);
      chk($sformatf("v%0d_ack_busy", i), busy4, 0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_cnt", i), cnt8, vt[i].c8);
      chk($sformatf("v%0d_idle_ovf4", i), ovf4, vt[i].o4);
    end

    // ack and start together in DONE: ack wins, start dropped
    per = 0;
    go(0);
    chk("z_done", done, 1);
    ack = 1'b1;
    start = 1'b1;
    win_len = 8'd5;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    chk("as_done", done, 0);
    chk("as_busy", busy, 0);
    @(negedge clk);
    chk("as_busy2", busy, 0);
    chk("as_done2", done, 0);

    // start during MEASURE is ignored
    go(10);
    repeat (3) @(negedge clk);
    start = 1'b1;
    win_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_lat", 6);
    do_ack();

    // stuck detector with constant q_in
    per = 0;
    repeat (8) @(negedge clk);
    go(40);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("stk15", stuck8, 0);
      if (k == 16) chk("stk16", stuck8, STK);
    end
    wait_done("stk_lat", 24);
    chk("stk_done", stuck8, STK);
    chk("stk_done4", stuck4, STK);
    do_ack();
    chk("stk_idle", stuck8, STK);
    go(0);
    chk("stk_clr", stuck8, 0);
    do_ack();

    // reset mid-window aborts with no done
    per = 1;
    repeat (8) @(negedge clk);
    go(30);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_cnt", cnt8, 0);
    chk("mr_ovf", ovf8, 0);
    chk("mr_edge", edge8, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mr_nodone", ndone, 0);

    // single one-cycle pulse gives two adjacent edge pulses
    per = -1;
    repeat (8) @(negedge clk);
    pulse_req = pulse_req + 1;
    first = -1;
    last = -1;
    npulse = 0;
    n4 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (edge8) begin
        npulse++;
        if (first < 0) first = i;
        last = i;
      end
      if (edge4) n4++;
    end
    chk("pl_count", npulse, 2);
    chk("pl_adj", last - first, 1);
    chk("pl_count4", n4, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
